// File: rtl/pcm_recorder_pkg.sv
// Shared types and helpers for the PCM DDR recorder: state encoding,
// word/lane geometry and circular-buffer address stepping.
package pcm_recorder_pkg;

  localparam int WORD_LANES     = 4;
  localparam int SAMPLE_WIDTH   = 16;
  localparam int DDR_ADDR_WIDTH = 27;
  localparam int WORD_WIDTH     = WORD_LANES * SAMPLE_WIDTH;
  localparam int LANE_BITS      = 2;
  localparam int COUNT_WIDTH    = 24;

  typedef enum logic [2:0] {
    IDLE,
    RECORD,
    FLUSH,
    RD_REQ,
    RD_WAIT,
    RD_OUT
  } recorder_state_t;

  // Advance a byte pointer by one 64-bit word, wrapping back to the
  // region base once the end of the region is reached.
  function automatic logic [DDR_ADDR_WIDTH-1:0] next_address(
    input logic [DDR_ADDR_WIDTH-1:0] ptr,
    input logic [DDR_ADDR_WIDTH-1:0] base,
    input logic [DDR_ADDR_WIDTH-1:0] limit
  );
    logic [DDR_ADDR_WIDTH-1:0] incr;
    incr = ptr + DDR_ADDR_WIDTH'(8);
    return (incr == limit) ? base : incr;
  endfunction

  // Pick one 16-bit lane out of a packed 64-bit word.
  function automatic logic [SAMPLE_WIDTH-1:0] lane_sample(
    input logic [WORD_WIDTH-1:0] word,
    input logic [LANE_BITS-1:0]  lane
  );
    return word[SAMPLE_WIDTH*lane +: SAMPLE_WIDTH];
  endfunction

endpackage

// File: rtl/pcm_sample_packer.sv
// Packs 16-bit samples into a 4-lane 64-bit word. word_ready_o pulses in
// the cycle the word is complete (4th sample or a flush of a partial
// word); word_o is the word to write in that cycle, unused lanes zeroed.
module pcm_sample_packer
  import pcm_recorder_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    clear_i,
  input  logic                    flush_i,
  input  logic                    valid_i,
  input  logic [SAMPLE_WIDTH-1:0] sample_i,
  output logic [WORD_WIDTH-1:0]   word_o,
  output logic                    word_ready_o,
  output logic [LANE_BITS-1:0]    lane_o
);

  logic [WORD_WIDTH-1:0] pack_q, pack_d;
  logic [LANE_BITS-1:0]  lane_q, lane_d;

  // Insert samples lane by lane, emit the word on completion or flush.
  always_comb begin
    pack_d       = pack_q;
    lane_d       = lane_q;
    word_o       = pack_q;
    word_ready_o = 1'b0;
    if (clear_i) begin
      pack_d = '0;
      lane_d = '0;
    end else if (flush_i) begin
      for (int i = 0; i < WORD_LANES; i++) begin
        if (i >= int'(lane_q)) word_o[SAMPLE_WIDTH*i +: SAMPLE_WIDTH] = '0;
      end
      word_ready_o = (lane_q != '0);
      pack_d       = '0;
      lane_d       = '0;
    end else if (valid_i) begin
      word_o[SAMPLE_WIDTH*lane_q +: SAMPLE_WIDTH] = sample_i;
      lane_d = lane_q + 2'd1;
      if (lane_q == 2'd3) begin
        word_ready_o = 1'b1;
        pack_d       = '0;
      end else begin
        pack_d = word_o;
      end
    end
  end

  // Pack register and lane counter; a reset discards any partial word.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pack_q <= '0;
      lane_q <= '0;
    end else begin
      pack_q <= pack_d;
      lane_q <= lane_d;
    end
  end

  assign lane_o = lane_q;

endmodule

// File: rtl/pcm_ddr_recorder.sv
// PCM recorder/player in front of ddr_interface. Records 16-bit samples
// as packed 64-bit words into a circular DDR region and plays them back.
// Build option: define PCM_RECORDER_LOOP_EN to make playback loop over the
// stored words until playback_i falls; otherwise it stops after the last.
module pcm_ddr_recorder
  import pcm_recorder_pkg::*;
#(
  parameter logic [DDR_ADDR_WIDTH-1:0] BASE_ADDRESS = 27'h0,
  parameter int unsigned               BUFFER_SIZE  = 2**20
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      record_i,
  input  logic                      playback_i,
  input  logic [SAMPLE_WIDTH-1:0]   sample_i,
  input  logic                      sample_valid_i,
  output logic [SAMPLE_WIDTH-1:0]   sample_o,
  output logic                      sample_valid_o,
  input  logic                      sample_request_i,
  output logic [COUNT_WIDTH-1:0]    stored_words_o,
  output logic                      busy_o,
  input  logic                      ready_i,
  output logic                      write_o,
  output logic [DDR_ADDR_WIDTH-1:0] write_address_o,
  output logic [WORD_WIDTH-1:0]     write_data_o,
  output logic                      read_o,
  output logic [DDR_ADDR_WIDTH-1:0] read_address_o,
  input  logic                      read_valid_i,
  input  logic [WORD_WIDTH-1:0]     read_data_i,
  output logic                      pull_data_o
);

  localparam logic [DDR_ADDR_WIDTH-1:0] END_ADDRESS =
    BASE_ADDRESS + DDR_ADDR_WIDTH'(BUFFER_SIZE);
  localparam logic [COUNT_WIDTH-1:0] MAX_WORDS = COUNT_WIDTH'(BUFFER_SIZE / 8);

  recorder_state_t             state_q, state_d;
  logic [DDR_ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_next;
  logic [COUNT_WIDTH-1:0]      stored_q, stored_d, rd_count_q, rd_count_d, rd_count_next;
  logic [LANE_BITS-1:0]        rd_lane_q, rd_lane_d, rd_lane_inc;
  logic [WORD_WIDTH-1:0]       unpack_q, unpack_d;
  logic                        write_q, write_d, read_q, read_d, pull_q, pull_d;
  logic                        sample_valid_q, sample_valid_d, busy_q, busy_d;
  logic [DDR_ADDR_WIDTH-1:0]   write_addr_q, write_addr_d, read_addr_q, read_addr_d;
  logic [WORD_WIDTH-1:0]       write_data_q, write_data_d;
  logic [SAMPLE_WIDTH-1:0]     sample_q, sample_d;

  logic                        pk_clear, pk_flush, pk_valid, pk_word_ready;
  logic [WORD_WIDTH-1:0]       pk_word;
  logic [LANE_BITS-1:0]        pk_lane;

  assign pk_clear = (state_q == IDLE) && ready_i && record_i;
  assign pk_valid = (state_q == RECORD) && record_i && sample_valid_i;
  assign pk_flush = (state_q == FLUSH);

  pcm_sample_packer u_packer (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .clear_i      (pk_clear),
    .flush_i      (pk_flush),
    .valid_i      (pk_valid),
    .sample_i     (sample_i),
    .word_o       (pk_word),
    .word_ready_o (pk_word_ready),
    .lane_o       (pk_lane)
  );

  // Next-state, pointer, command and unpack logic for the whole recorder.
  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    stored_d       = stored_q;
    rd_count_d     = rd_count_q;
    rd_lane_d      = rd_lane_q;
    unpack_d       = unpack_q;
    write_d        = 1'b0;
    write_addr_d   = write_addr_q;
    write_data_d   = write_data_q;
    read_d         = 1'b0;
    read_addr_d    = read_addr_q;
    pull_d         = 1'b0;
    sample_d       = sample_q;
    sample_valid_d = sample_valid_q;
    rd_ptr_next    = next_address(rd_ptr_q, BASE_ADDRESS, END_ADDRESS);
    rd_count_next  = rd_count_q + 24'd1;
    rd_lane_inc    = rd_lane_q + 2'd1;

    case (state_q)
      IDLE: begin
        if (ready_i) begin
          if (record_i) begin
            state_d  = RECORD;
            wr_ptr_d = BASE_ADDRESS;
            stored_d = '0;
          end else if (playback_i && (stored_q != '0)) begin
            state_d     = RD_REQ;
            rd_ptr_d    = BASE_ADDRESS;
            rd_count_d  = '0;
            read_d      = 1'b1;
            read_addr_d = BASE_ADDRESS;
          end
        end
      end
      RECORD: begin
        if (!record_i) state_d = (pk_lane != '0) ? FLUSH : IDLE;
      end
      FLUSH: begin
        state_d = IDLE;
      end
      RD_REQ: begin
        state_d = playback_i ? RD_WAIT : IDLE;
      end
      RD_WAIT: begin
        if (read_valid_i) begin
          pull_d = 1'b1;
          if (playback_i) begin
            unpack_d  = read_data_i;
            rd_lane_d = '0;
            state_d   = RD_OUT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      RD_OUT: begin
        if (!playback_i) begin
          sample_valid_d = 1'b0;
          state_d        = IDLE;
        end else if (!sample_valid_q) begin
          sample_valid_d = 1'b1;
          sample_d       = lane_sample(unpack_q, rd_lane_q);
        end else if (sample_request_i) begin
          rd_lane_d = rd_lane_inc;
          if (rd_lane_q == 2'd3) begin
            sample_valid_d = 1'b0;
            rd_ptr_d       = rd_ptr_next;
            rd_count_d     = rd_count_next;
            if (rd_count_next == stored_q) begin
`ifdef PCM_RECORDER_LOOP_EN
              rd_ptr_d    = BASE_ADDRESS;
              rd_count_d  = '0;
              state_d     = RD_REQ;
              read_d      = 1'b1;
              read_addr_d = BASE_ADDRESS;
`else
              state_d = IDLE;
`endif
            end else begin
              state_d     = RD_REQ;
              read_d      = 1'b1;
              read_addr_d = rd_ptr_next;
            end
          end else begin
            sample_d = lane_sample(unpack_q, rd_lane_inc);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pk_word_ready) begin
      write_d      = 1'b1;
      write_addr_d = wr_ptr_q;
      write_data_d = pk_word;
      wr_ptr_d     = next_address(wr_ptr_q, BASE_ADDRESS, END_ADDRESS);
      stored_d     = (stored_q == MAX_WORDS) ? stored_q : stored_q + 24'd1;
    end
  end

  assign busy_d = (state_d != IDLE);

  // State and registered outputs; reset aborts any transfer in progress.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q        <= IDLE;
      wr_ptr_q       <= BASE_ADDRESS;
      rd_ptr_q       <= BASE_ADDRESS;
      stored_q       <= '0;
      rd_count_q     <= '0;
      rd_lane_q      <= '0;
      unpack_q       <= '0;
      write_q        <= 1'b0;
      write_addr_q   <= '0;
      write_data_q   <= '0;
      read_q         <= 1'b0;
      read_addr_q    <= '0;
      pull_q         <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      stored_q       <= stored_d;
      rd_count_q     <= rd_count_d;
      rd_lane_q      <= rd_lane_d;
      unpack_q       <= unpack_d;
      write_q        <= write_d;
      write_addr_q   <= write_addr_d;
      write_data_q   <= write_data_d;
      read_q         <= read_d;
      read_addr_q    <= read_addr_d;
      pull_q         <= pull_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign sample_o        = sample_q;
  assign sample_valid_o  = sample_valid_q;
  assign stored_words_o  = stored_q;
  assign busy_o          = busy_q;
  assign write_o         = write_q;
  assign write_address_o = write_addr_q;
  assign write_data_o    = write_data_q;
  assign read_o          = read_q;
  assign read_address_o  = read_addr_q;
  assign pull_data_o     = pull_q;

endmodule

// File: tb/tb_pcm_ddr_recorder.sv
// Self-checking bench for pcm_ddr_recorder with a 32-byte region.
// Expected DDR writes, reads and played-back samples are pushed to queues
// by a bench-side model and popped as the DUT produces them.
module tb_pcm_ddr_recorder;

  localparam int BUF_BYTES = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        record_i = 1'b0;
  logic        playback_i = 1'b0;
  logic [15:0] sample_i = '0;
  logic        sample_valid_i = 1'b0;
  logic [15:0] sample_o;
  logic        sample_valid_o;
  logic        sample_request_i = 1'b0;
  logic [23:0] stored_words_o;
  logic        busy_o;
  logic        ready_i = 1'b1;
  logic        write_o;
  logic [26:0] write_address_o;
  logic [63:0] write_data_o;
  logic        read_o;
  logic [26:0] read_address_o;
  logic        read_valid_i = 1'b0;
  logic [63:0] read_data_i = '0;
  logic        pull_data_o;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [26:0] addr;
    logic [63:0] data;
  } wr_exp_t;

  wr_exp_t     wr_q[$];
  logic [26:0] rd_q[$];
  logic [15:0] smp_q[$];

  // Bench model of the recording side, and the bench's DDR contents.
  logic [63:0] model_mem [0:3];
  logic [63:0] ddr_mem [0:3];
  logic [63:0] model_word = '0;
  logic [26:0] model_ptr = '0;
  int          model_lane = 0;
  int          model_stored = 0;

  // Responder state for the emulated read FIFO.
  bit          rd_pending = 0;
  int          rd_delay = 0;
  logic [26:0] rd_addr = '0;
  bit          valid_new = 0;

  pcm_ddr_recorder #(
    .BASE_ADDRESS (27'h0),
    .BUFFER_SIZE  (BUF_BYTES)
  ) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .record_i         (record_i),
    .playback_i       (playback_i),
    .sample_i         (sample_i),
    .sample_valid_i   (sample_valid_i),
    .sample_o         (sample_o),
    .sample_valid_o   (sample_valid_o),
    .sample_request_i (sample_request_i),
    .stored_words_o   (stored_words_o),
    .busy_o           (busy_o),
    .ready_i          (ready_i),
    .write_o          (write_o),
    .write_address_o  (write_address_o),
    .write_data_o     (write_data_o),
    .read_o           (read_o),
    .read_address_o   (read_address_o),
    .read_valid_i     (read_valid_i),
    .read_data_i      (read_data_i),
    .pull_data_o      (pull_data_o)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_write"}, 64'(write_o), 64'd0);
    checkOutput({tag, "_read"}, 64'(read_o), 64'd0);
    checkOutput({tag, "_pull"}, 64'(pull_data_o), 64'd0);
    checkOutput({tag, "_sample_valid"}, 64'(sample_valid_o), 64'd0);
    checkOutput({tag, "_sample"}, 64'(sample_o), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy_o), 64'd0);
    checkOutput({tag, "_stored"}, 64'(stored_words_o), 64'd0);
    checkOutput({tag, "_write_data"}, write_data_o, 64'd0);
    checkOutput({tag, "_write_addr"}, 64'(write_address_o), 64'd0);
    checkOutput({tag, "_read_addr"}, 64'(read_address_o), 64'd0);
  endtask

  // Model: commit the current model word as an expected DDR write.
  task automatic pushWord();
    wr_q.push_back({model_ptr, model_word});
    model_mem[model_ptr[4:3]] = model_word;
    model_ptr = model_ptr + 27'd8;
    if (model_ptr == 27'(BUF_BYTES)) model_ptr = '0;
    if (model_stored < BUF_BYTES / 8) model_stored++;
    model_word = '0;
    model_lane = 0;
  endtask

  // Drive one sample, then honour the 8-cycle spacing between samples.
  task automatic applyStimulus(input logic [15:0] s);
    bit completes;
    model_word[16*model_lane +: 16] = s;
    model_lane++;
    completes = (model_lane == 4);
    if (completes) pushWord();
    sample_i = s;
    sample_valid_i = 1'b1;
    @(negedge clk);
    sample_valid_i = 1'b0;
    checkOutput("write_latency", 64'(write_o), 64'(completes));
    repeat (8) @(negedge clk);
  endtask

  task automatic startRecord();
    record_i = 1'b1;
    model_ptr = '0;
    model_stored = 0;
    model_lane = 0;
    model_word = '0;
    repeat (2) @(negedge clk);
    checkOutput("record_busy", 64'(busy_o), 64'd1);
  endtask

  task automatic stopRecord();
    record_i = 1'b0;
    if (model_lane != 0) pushWord();
    repeat (6) @(negedge clk);
    checkOutput("stored_words", 64'(stored_words_o), 64'(model_stored));
    checkOutput("idle_after_record", 64'(busy_o), 64'd0);
  endtask

  // Consume nsamp played-back samples, requesting each one as it shows.
  task automatic playWords(input int nsamp, input bit drop_last);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (got < nsamp && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (sample_valid_o) begin
        if (smp_q.size() == 0) checkOutput("sample_extra", 64'd1, 64'd0);
        else checkOutput("sample", 64'(sample_o), 64'(smp_q.pop_front()));
        got++;
        sample_request_i = 1'b1;
        if (drop_last && got == nsamp) playback_i = 1'b0;
      end else begin
        sample_request_i = 1'b0;
      end
    end
    if (got < nsamp) checkOutput("sample_timeout", 64'(got), 64'(nsamp));
    @(negedge clk);
    sample_request_i = 1'b0;
  endtask

  // Monitor DDR commands against the expected write/read queues.
  always @(negedge clk) begin : cmd_monitor
    wr_exp_t e;
    if (rst_n) begin
      if (write_o) begin
        if (read_o) checkOutput("wr_rd_exclusive", 64'(read_o), 64'd0);
        ddr_mem[write_address_o[4:3]] = write_data_o;
        if (wr_q.size() == 0) checkOutput("unexpected_write", 64'(write_o), 64'd0);
        else begin
          e = wr_q.pop_front();
          checkOutput("write_addr", 64'(write_address_o), 64'(e.addr));
          checkOutput("write_data", write_data_o, e.data);
        end
      end
      if (read_o) begin
        if (rd_q.size() == 0) checkOutput("unexpected_read", 64'(read_o), 64'd0);
        else checkOutput("read_addr", 64'(read_address_o), 64'(rd_q.pop_front()));
      end
    end
  end

  // Emulated first-word-fall-through read FIFO answering DUT reads.
  always @(negedge clk) begin : ddr_responder
    if (!rst_n) begin
      read_valid_i = 1'b0;
      rd_pending = 0;
      valid_new = 0;
    end else begin
      if (valid_new) begin
        checkOutput("pull_latency", 64'(pull_data_o), 64'd1);
        valid_new = 0;
      end
      if (pull_data_o) read_valid_i = 1'b0;
      if (read_o) begin
        rd_pending = 1;
        rd_delay = 3;
        rd_addr = read_address_o;
      end else if (rd_pending) begin
        rd_delay--;
        if (rd_delay == 0) begin
          read_valid_i = 1'b1;
          read_data_i = ddr_mem[rd_addr[4:3]];
          rd_pending = 0;
          valid_new = 1;
        end
      end
    end
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // ready_i low keeps the recorder idle even with record requested.
    ready_i = 1'b0;
    record_i = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("ready_gate", 64'(busy_o), 64'd0);
    record_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);

    // One full word.
    $display("[TB] record 4 samples");
    startRecord();
    applyStimulus(16'h1111);
    applyStimulus(16'h2222);
    applyStimulus(16'h3333);
    applyStimulus(16'h4444);
    checkOutput("one_word_stored", 64'(stored_words_o), 64'd1);
    stopRecord();

    // Six samples: one full word plus a zero-filled flush word at 8.
    $display("[TB] record 6 samples with flush");
    startRecord();
    applyStimulus(16'h1111);
    applyStimulus(16'h2222);
    applyStimulus(16'h3333);
    applyStimulus(16'h4444);
    applyStimulus(16'h5555);
    applyStimulus(16'h6666);
    stopRecord();

    // Play back the two stored words.
    $display("[TB] playback two words");
    rd_q.push_back(27'h0);
    rd_q.push_back(27'h8);
    for (int w = 0; w < 2; w++)
      for (int l = 0; l < 4; l++) smp_q.push_back(model_mem[w][16*l +: 16]);
`ifdef PCM_RECORDER_LOOP_EN
    rd_q.push_back(27'h0);
`endif
    playback_i = 1'b1;
    playWords(8, 1'b0);
`ifdef PCM_RECORDER_LOOP_EN
    checkOutput("loop_reread_busy", 64'(busy_o), 64'd1);
    for (int l = 0; l < 4; l++) smp_q.push_back(model_mem[0][16*l +: 16]);
    playWords(4, 1'b1);
`else
    checkOutput("playback_end_idle", 64'(busy_o), 64'd0);
    playback_i = 1'b0;
`endif
    repeat (6) @(negedge clk);
    checkOutput("idle_after_playback", 64'(busy_o), 64'd0);
    checkOutput("reads_consumed", 64'(rd_q.size()), 64'd0);

    // Five words into a four-word region: wrap and saturation.
    $display("[TB] record 5 words into 32-byte region");
    startRecord();
    for (int i = 0; i < 20; i++) applyStimulus(16'hA000 + 16'(i));
    stopRecord();
    checkOutput("stored_saturated", 64'(stored_words_o), 64'd4);

    // Record and playback together: record wins, no read issued.
    $display("[TB] record and playback together");
    playback_i = 1'b1;
    startRecord();
    applyStimulus(16'hBEEF);
    applyStimulus(16'hCAFE);
    applyStimulus(16'h0123);
    applyStimulus(16'h4567);
    playback_i = 1'b0;
    stopRecord();

    // Asynchronous reset with a half-packed word discards it.
    $display("[TB] reset mid-word");
    startRecord();
    applyStimulus(16'h7777);
    applyStimulus(16'h8888);
    #2 rst_n = 1'b0;
    #1 checkResetOutputs("async_reset");
    record_i = 1'b0;
    model_lane = 0;
    model_word = '0;
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("post_reset_busy", 64'(busy_o), 64'd0);
    checkOutput("post_reset_stored", 64'(stored_words_o), 64'd0);

    checkOutput("writes_consumed", 64'(wr_q.size()), 64'd0);
    checkOutput("samples_consumed", 64'(smp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
